// File: rtl/ofdm_frame_packetizer.sv
// Packs the OFDM framer's symbol stream into one AXI-Stream packet per frame through a cut-through FIFO.
// Define OFDM_PACKETIZER_STATS_EN to build the o_frames_ok / o_frames_err saturating counters.
module ofdm_frame_packetizer #(
  parameter int WIDTH           = 32,
  parameter int SYMBOL_LEN      = 64,
  parameter int FIFO_DEPTH_LOG2 = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic             i_sof,
  input  logic             i_eof,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_terror,
  output logic [15:0]      o_frames_ok,
  output logic [15:0]      o_frames_err
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW    = (SYMBOL_LEN > 1) ? $clog2(SYMBOL_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(SYMBOL_LEN - 1);
  localparam logic [BW-1:0] FIRST_NEXT = (SYMBOL_LEN > 1) ? BW'(1) : '0;
  localparam logic [FIFO_DEPTH_LOG2:0] DATA_LIMIT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

  state_t                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [WIDTH+1:0]           mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;

  logic             accept, data_full, len_err;
  logic             wr_en, wr_last, wr_err, rd_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH+1:0] rd_entry;

  assign i_tready  = reset_n;
  assign accept    = i_tvalid & reset_n;
  // The top slot is held back so a terminator can always be written.
  assign data_full = (count_q >= DATA_LIMIT);
  assign len_err   = i_tlast ^ (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wr_en   = 1'b0;
    wr_data = i_tdata;
    wr_last = 1'b0;
    wr_err  = 1'b0;
    if (accept) begin
      case (state_q)
        S_FRAME: begin
          if (i_sof || data_full || len_err) begin
            wr_en   = 1'b1;
            wr_data = '0;
            wr_last = 1'b1;
            wr_err  = 1'b1;
            beat_d  = '0;
            state_d = S_DROP;
          end else if (i_tlast && i_eof) begin
            wr_en   = 1'b1;
            wr_last = 1'b1;
            beat_d  = '0;
            state_d = S_IDLE;
          end else begin
            wr_en  = 1'b1;
            beat_d = i_tlast ? '0 : beat_q + 1'b1;
          end
        end
        default: begin
          if (i_sof) begin
            if (data_full) begin
              state_d = S_DROP;
            end else begin
              wr_en   = 1'b1;
              beat_d  = FIRST_NEXT;
              state_d = S_FRAME;
            end
          end else if (i_tlast && i_eof) begin
            state_d = S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_data, wr_last, wr_err};
  end

  assign rd_entry = mem_q[rd_ptr_q];
  assign o_tvalid = (count_q != '0);
  assign rd_en    = o_tvalid & o_tready;
  assign o_tdata  = o_tvalid ? rd_entry[WIDTH+1:2] : '0;
  assign o_tlast  = o_tvalid & rd_entry[1];
  assign o_terror = o_tvalid & rd_entry[0];

`ifdef OFDM_PACKETIZER_STATS_EN
  logic [15:0] ok_q, err_q;
  logic        ok_evt, err_evt;

  // Every terminator is an error; a frame start refused by a full FIFO is one too.
  assign ok_evt  = wr_en & wr_last & ~wr_err;
  assign err_evt = (wr_en & wr_err) | (accept & i_sof & (state_q != S_FRAME) & data_full);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ok_q  <= '0;
      err_q <= '0;
    end else begin
      if (ok_evt && (ok_q != 16'hFFFF))   ok_q  <= ok_q + 1'b1;
      if (err_evt && (err_q != 16'hFFFF)) err_q <= err_q + 1'b1;
    end
  end

  assign o_frames_ok  = ok_q;
  assign o_frames_err = err_q;
`else
  assign o_frames_ok  = '0;
  assign o_frames_err = '0;
`endif

endmodule

// File: tb/tb_ofdm_frame_packetizer.sv
// Directed self-checking bench for ofdm_frame_packetizer (default parameters).
module tb_ofdm_frame_packetizer;
  localparam int WIDTH = 32;
  localparam int SYMBOL_LEN = 64;
  localparam int FIFO_DEPTH_LOG2 = 9;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tlast = 1'b0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic             i_sof = 1'b0;
  logic             i_eof = 1'b0;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready = 1'b0;
  logic             o_terror;
  logic [15:0]      o_frames_ok;
  logic [15:0]      o_frames_err;

  always #5 clk = ~clk;

  ofdm_frame_packetizer #(
    .WIDTH(WIDTH), .SYMBOL_LEN(SYMBOL_LEN), .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .i_sof(i_sof), .i_eof(i_eof),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_terror(o_terror), .o_frames_ok(o_frames_ok), .o_frames_err(o_frames_err)
  );

  int compared = 0;
  int mismatched = 0;
  int nOk = 0;
  int nErr = 0;

  logic [WIDTH-1:0] gotData[$];
  logic             gotLast[$];
  logic             gotErr[$];
  logic [WIDTH-1:0] expData[$];
  logic             expLast[$];
  logic             expErrQ[$];

  // A beat seen valid and ready at the falling edge pops on the next rising edge.
  always @(negedge clk) begin
    if (reset_n && o_tvalid && o_tready) begin
      gotData.push_back(o_tdata);
      gotLast.push_back(o_tlast);
      gotErr.push_back(o_terror);
    end
  end

  function automatic logic [WIDTH-1:0] dataOf(input logic [7:0] tag, input int idx);
    return {tag, idx[23:0]};
  endfunction

  function automatic logic [15:0] statsExp(input int n);
`ifdef OFDM_PACKETIZER_STATS_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic clearQueues();
    gotData.delete(); gotLast.delete(); gotErr.delete();
    expData.delete(); expLast.delete(); expErrQ.delete();
  endtask

  task automatic pushExp(input logic [WIDTH-1:0] d, input logic l, input logic e);
    expData.push_back(d); expLast.push_back(l); expErrQ.push_back(e);
  endtask

  task automatic pushFrameExp(input logic [7:0] tag, input int nBeats, input int lastAt);
    for (int k = 0; k < nBeats; k++) pushExp(dataOf(tag, k), k == lastAt, 1'b0);
  endtask

  task automatic send_sample(input logic [WIDTH-1:0] d, input logic last,
                             input logic sof, input logic eof);
    i_tdata = d; i_tlast = last; i_sof = sof; i_eof = eof; i_tvalid = 1'b1;
    @(posedge clk); #1;
    i_tvalid = 1'b0; i_tlast = 1'b0; i_sof = 1'b0; i_eof = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] tag, input int nSym);
    for (int i = 0; i < nSym * SYMBOL_LEN; i++)
      send_sample(dataOf(tag, i), (i % SYMBOL_LEN) == SYMBOL_LEN - 1, i == 0,
                  i >= (nSym - 1) * SYMBOL_LEN);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (o_tvalid !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (n >= 3000) begin
      mismatched++;
      $display("[TB] FAIL %s drain: o_tvalid=%b after %0d cycles, want 0", name, o_tvalid, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; o_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (i_tready !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_tready: got %b want 0", i_tready);
    end
    compared++;
    if ({o_tvalid, o_tlast, o_terror} !== 3'b000) begin
      mismatched++; $display("[TB] FAIL reset_outputs: got valid/last/err=%b want 000", {o_tvalid, o_tlast, o_terror});
    end
    compared++;
    if (o_frames_ok !== 16'd0 || o_frames_err !== 16'd0) begin
      mismatched++; $display("[TB] FAIL reset_counters: got ok=%0d err=%0d want 0/0", o_frames_ok, o_frames_err);
    end
    reset_n = 1'b1;
    #1;
    compared++;
    if (i_tready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL run_tready: got %b want 1", i_tready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    clearQueues(); o_tready = 1'b1;
    send_sample(dataOf(8'h01, 0), 1'b0, 1'b1, 1'b0);
    compared++;
    if (o_tvalid !== 1'b1 || o_tdata !== dataOf(8'h01, 0)) begin
      mismatched++; $display("[TB] FAIL nominal_latency: got valid=%b data=%h want 1/%h", o_tvalid, o_tdata, dataOf(8'h01, 0));
    end
    for (int i = 1; i < 192; i++) send_sample(dataOf(8'h01, i), (i % 64) == 63, 1'b0, i >= 128);
    wait_drain("nominal");
    nOk++;
    pushFrameExp(8'h01, 192, 191);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL nominal_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL nominal_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
    compared++;
    if (o_frames_ok !== statsExp(nOk) || o_frames_err !== statsExp(nErr)) begin
      mismatched++; $display("[TB] FAIL nominal_counters: got ok=%0d err=%0d want %0d/%0d", o_frames_ok, o_frames_err, statsExp(nOk), statsExp(nErr));
    end
  endtask

  task automatic test_discard();
    clearQueues(); o_tready = 1'b1;
    for (int i = 0; i < 50; i++) send_sample(dataOf(8'hEE, i), (i % 7) == 6, 1'b0, (i % 5) == 0);
    send_frame(8'h02, 1);
    wait_drain("discard");
    nOk++;
    pushFrameExp(8'h02, 64, 63);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL discard_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL discard_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
  endtask

  task automatic test_overflow();
    clearQueues(); o_tready = 1'b0;
    send_frame(8'h03, 10);
    nErr++;
    compared++;
    if (o_tvalid !== 1'b1 || o_tdata !== dataOf(8'h03, 0) || o_tlast !== 1'b0) begin
      mismatched++; $display("[TB] FAIL overflow_head: got valid=%b data=%h last=%b want 1/%h/0", o_tvalid, o_tdata, o_tlast, dataOf(8'h03, 0));
    end
    compared++;
    if (o_frames_err !== statsExp(nErr) || o_frames_ok !== statsExp(nOk)) begin
      mismatched++; $display("[TB] FAIL overflow_counters: got ok=%0d err=%0d want %0d/%0d", o_frames_ok, o_frames_err, statsExp(nOk), statsExp(nErr));
    end
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (o_tvalid !== 1'b1 || o_tdata !== dataOf(8'h03, 0)) begin
      mismatched++; $display("[TB] FAIL overflow_hold: got valid=%b data=%h want 1/%h", o_tvalid, o_tdata, dataOf(8'h03, 0));
    end
    o_tready = 1'b1;
    wait_drain("overflow");
    for (int k = 0; k < 511; k++) pushExp(dataOf(8'h03, k), 1'b0, 1'b0);
    pushExp('0, 1'b1, 1'b1);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL overflow_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL overflow_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
    clearQueues();
    send_frame(8'h04, 1);
    wait_drain("overflow_next");
    nOk++;
    pushFrameExp(8'h04, 64, 63);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL overflow_next_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL overflow_next_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
  endtask

  task automatic test_bad_length();
    clearQueues(); o_tready = 1'b1;
    for (int i = 0; i < 64; i++) send_sample(dataOf(8'h05, i), i == 63, i == 0, 1'b0);
    for (int i = 0; i < 64; i++) send_sample(dataOf(8'h05, 64 + i), i == 40 || i == 63, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) send_sample(dataOf(8'h05, 128 + i), i == 63, 1'b0, 1'b1);
    send_frame(8'h06, 1);
    wait_drain("bad_length");
    nErr++; nOk++;
    for (int k = 0; k < 104; k++) pushExp(dataOf(8'h05, k), 1'b0, 1'b0);
    pushExp('0, 1'b1, 1'b1);
    for (int k = 0; k < 64; k++) pushExp(dataOf(8'h06, k), k == 63, 1'b0);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL bad_length_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL bad_length_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
    compared++;
    if (o_frames_ok !== statsExp(nOk) || o_frames_err !== statsExp(nErr)) begin
      mismatched++; $display("[TB] FAIL bad_length_counters: got ok=%0d err=%0d want %0d/%0d", o_frames_ok, o_frames_err, statsExp(nOk), statsExp(nErr));
    end
  endtask

  task automatic test_missing_eof();
    clearQueues(); o_tready = 1'b1;
    for (int i = 0; i < 74; i++) send_sample(dataOf(8'h07, i), i == 63, i == 0, 1'b0);
    send_frame(8'h08, 1);
    send_frame(8'h09, 1);
    wait_drain("missing_eof");
    nErr++; nOk++;
    for (int k = 0; k < 74; k++) pushExp(dataOf(8'h07, k), 1'b0, 1'b0);
    pushExp('0, 1'b1, 1'b1);
    pushFrameExp(8'h09, 64, 63);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL missing_eof_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL missing_eof_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
    compared++;
    if (o_frames_ok !== statsExp(nOk) || o_frames_err !== statsExp(nErr)) begin
      mismatched++; $display("[TB] FAIL missing_eof_counters: got ok=%0d err=%0d want %0d/%0d", o_frames_ok, o_frames_err, statsExp(nOk), statsExp(nErr));
    end
  endtask

  task automatic test_back_to_back();
    clearQueues(); o_tready = 1'b1;
    send_frame(8'h12, 1);
    send_frame(8'h13, 1);
    wait_drain("back_to_back");
    nOk += 2;
    pushFrameExp(8'h12, 64, 63);
    pushFrameExp(8'h13, 64, 63);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL back_to_back_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL back_to_back_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
    compared++;
    if (o_frames_ok !== statsExp(nOk) || o_frames_err !== statsExp(nErr)) begin
      mismatched++; $display("[TB] FAIL back_to_back_counters: got ok=%0d err=%0d want %0d/%0d", o_frames_ok, o_frames_err, statsExp(nOk), statsExp(nErr));
    end
  endtask

  task automatic test_reset_mid();
    clearQueues(); o_tready = 1'b1;
    for (int i = 0; i < 30; i++) send_sample(dataOf(8'h10, i), 1'b0, i == 0, 1'b0);
    reset_n = 1'b0;
    i_tdata = dataOf(8'h10, 30); i_tvalid = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1; i_tvalid = 1'b0;
    nOk = 0; nErr = 0;
    compared++;
    if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_terror !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_mid_outputs: got valid/last/err=%b want 000", {o_tvalid, o_tlast, o_terror});
    end
    compared++;
    if (o_frames_ok !== 16'd0 || o_frames_err !== 16'd0) begin
      mismatched++; $display("[TB] FAIL reset_mid_counters: got ok=%0d err=%0d want 0/0", o_frames_ok, o_frames_err);
    end
    clearQueues();
    for (int i = 31; i < 64; i++) send_sample(dataOf(8'h10, i), i == 63, 1'b0, 1'b1);
    send_frame(8'h11, 1);
    wait_drain("reset_mid");
    nOk++;
    pushFrameExp(8'h11, 64, 63);
    compared++;
    if (gotData.size() != expData.size()) begin
      mismatched++; $display("[TB] FAIL reset_mid_count: got %0d beats want %0d", gotData.size(), expData.size());
    end
    for (int k = 0; k < gotData.size() && k < expData.size(); k++) begin
      compared++;
      if (gotData[k] !== expData[k] || gotLast[k] !== expLast[k] || gotErr[k] !== expErrQ[k]) begin
        mismatched++;
        $display("[TB] FAIL reset_mid_beat %0d: got %h/%b/%b want %h/%b/%b", k, gotData[k], gotLast[k], gotErr[k], expData[k], expLast[k], expErrQ[k]);
      end
    end
    compared++;
    if (o_frames_ok !== statsExp(nOk) || o_frames_err !== statsExp(nErr)) begin
      mismatched++; $display("[TB] FAIL reset_mid_final_counters: got ok=%0d err=%0d want %0d/%0d", o_frames_ok, o_frames_err, statsExp(nOk), statsExp(nErr));
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_discard();
    test_overflow();
    test_bad_length();
    test_missing_eof();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
